// File: rtl/sng_pkg.sv
// Shared types and helpers for the multi-channel stochastic number generator.
// Holds the FSM state type, maximal-length LFSR tap masks and the bipolar offset.
package sng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit i set means register bit i feeds the XOR; all polynomials are primitive.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] t;
        case (width)
            4:       t = 16'h000C;
            5:       t = 16'h0014;
            6:       t = 16'h0030;
            7:       t = 16'h0060;
            8:       t = 16'h00B8;
            9:       t = 16'h0110;
            10:      t = 16'h0240;
            11:      t = 16'h0500;
            12:      t = 16'h0829;
            13:      t = 16'h100D;
            14:      t = 16'h2015;
            15:      t = 16'h6000;
            16:      t = 16'hD008;
            default: t = 16'h000C;
        endcase
        return t;
    endfunction

    function automatic logic [15:0] bipolar_offset(input int width);
        return 16'h0001 << (width - 1);
    endfunction

endpackage

// File: rtl/sng_lfsr.sv
// Fibonacci maximal-length LFSR, shifting left with feedback into bit 0.
// Load and reset both place the seed; the seed must be nonzero.
module sng_lfsr
    import sng_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_q
);

    localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             w_fb;

    assign w_fb = ^(r_q & TAPS);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_load) begin
            r_q <= i_seed;
        end else if (i_en) begin
            r_q <= {r_q[WIDTH-2:0], w_fb};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sng_multi.sv
// Multi-channel SNG: one shared LFSR, per-channel rotated copies compared
// against captured operands, framed by a start/stop/last/done FSM.
module sng_multi
    import sng_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SEED  = 1
) (
    input  logic              i_clk_msng,
    input  logic              i_rst_msng,
    input  logic              i_start_msng,
    input  logic              i_stop_msng,
    input  logic              i_mode_msng,
    input  logic [WIDTH-1:0]  i_len_msng,
    input  logic [CH*WIDTH-1:0] i_x_bn,
    output logic [CH-1:0]     o_sn_bits,
    output logic              o_valid_msng,
    output logic              o_last_msng,
    output logic              o_done_msng,
    output logic              o_busy_msng
);

    localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] SEED_EFF =
        (SEED_W == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED_W;
    localparam logic [15:0]      OFS_ALL  = bipolar_offset(WIDTH);
    localparam logic [WIDTH-1:0] OFS      = OFS_ALL[WIDTH-1:0];

    state_t              r_state;
    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_len;
    logic [CH*WIDTH-1:0] r_x;
    logic                r_mode;

    logic [WIDTH-1:0]    w_lfsr;
    logic                w_go;
    logic                w_valid;
    logic                w_last;

    assign w_go    = (r_state == ST_IDLE) && i_start_msng && !i_stop_msng;
    assign w_valid = (r_state == ST_RUN);
    assign w_last  = w_valid && (r_cnt == r_len - 1'b1);

    always_ff @(posedge i_clk_msng) begin
        if (i_rst_msng) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_x     <= '0;
            r_mode  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_x     <= i_x_bn;
                        r_mode  <= i_mode_msng;
                        r_len   <= i_len_msng;
                        r_cnt   <= '0;
                        r_state <= (i_len_msng != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    // An abort on the final bit still skips the done pulse.
                    if (i_stop_msng) begin
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sng_lfsr #(
        .WIDTH (WIDTH)
    ) u_lfsr (
        .i_clk  (i_clk_msng),
        .i_rst  (i_rst_msng),
        .i_load (w_go),
        .i_seed (SEED_EFF),
        .i_en   (w_valid),
        .o_q    (w_lfsr)
    );

    for (genvar k = 0; k < CH; k++) begin : g_lane
        logic [WIDTH-1:0] w_r;
        logic [WIDTH-1:0] w_xe;

        if (k == 0) begin : g_norot
            assign w_r = w_lfsr;
        end else begin : g_rot
            assign w_r = {w_lfsr[WIDTH-1-k:0], w_lfsr[WIDTH-1:WIDTH-k]};
        end

        assign w_xe = r_x[k*WIDTH +: WIDTH] ^ (r_mode ? OFS : '0);
        assign o_sn_bits[k] = w_valid && (w_r <= w_xe);
    end

    assign o_valid_msng = w_valid;
    assign o_last_msng  = w_last;
    assign o_done_msng  = (r_state == ST_DONE);
    assign o_busy_msng  = (r_state != ST_IDLE);

endmodule
